// File: rtl/key_command_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared types and helpers for the key command conditioner.
//   cmd_t           : game command codes handed to the game controller
//   state_t         : press-tracking FSM states
//   KC_*            : USB HID keycodes recognised by the conditioner
//   keycode_to_cmd  : maps an accepted keycode to a command
//   is_shift_cmd    : true for the commands that use DAS + auto-repeat
// Optional build macro: KEYCOND_WASD_EN adds the W/A/S/D alternate bindings.
// -----------------------------------------------------------------------------
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_LEFT      = 3'd1,
        CMD_RIGHT     = 3'd2,
        CMD_DOWN      = 3'd3,
        CMD_ROTATE    = 3'd4,
        CMD_HARD_DROP = 3'd5,
        CMD_RESTART   = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_DAS    = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    localparam logic [7:0] KC_NONE      = 8'h00;
    localparam logic [7:0] KC_LEFT      = 8'h50;
    localparam logic [7:0] KC_RIGHT     = 8'h4F;
    localparam logic [7:0] KC_DOWN      = 8'h51;
    localparam logic [7:0] KC_UP        = 8'h52;
    localparam logic [7:0] KC_SPACE     = 8'h2C;
    localparam logic [7:0] KC_F9        = 8'h42;
    localparam logic [7:0] KC_A         = 8'h04;
    localparam logic [7:0] KC_D         = 8'h07;
    localparam logic [7:0] KC_S         = 8'h16;
    localparam logic [7:0] KC_W         = 8'h1A;

    // Anything not listed is treated exactly like a released key.
    function automatic cmd_t keycode_to_cmd(input logic [7:0] kc);
        cmd_t c;
        c = CMD_NONE;
        case (kc)
            KC_LEFT:  c = CMD_LEFT;
            KC_RIGHT: c = CMD_RIGHT;
            KC_DOWN:  c = CMD_DOWN;
            KC_UP:    c = CMD_ROTATE;
            KC_SPACE: c = CMD_HARD_DROP;
            KC_F9:    c = CMD_RESTART;
`ifdef KEYCOND_WASD_EN
            KC_A:     c = CMD_LEFT;
            KC_D:     c = CMD_RIGHT;
            KC_S:     c = CMD_DOWN;
            KC_W:     c = CMD_ROTATE;
`endif
            default:  c = CMD_NONE;
        endcase
        return c;
    endfunction

    function automatic logic is_shift_cmd(input cmd_t c);
        return (c == CMD_LEFT) || (c == CMD_RIGHT);
    endfunction

endpackage

// File: rtl/key_command_conditioner_stabilizer.sv
// -----------------------------------------------------------------------------
// keycode_stabilizer
// Glitch filter for the keycode register written by the soft processor.
// A new keycode is only accepted once it has been sampled unchanged on
// STABLE_CYCLES+1 consecutive clocks.
// Ports:
//   clk_i       : system clock
//   reset_i     : synchronous active-high reset
//   keycode_i   : raw HID keycode
//   accepted_o  : last keycode that survived the stability filter
// -----------------------------------------------------------------------------
module keycode_stabilizer #(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] keycode_i,
    output logic [7:0] accepted_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_CYCLES - 1);

    logic [7:0]    kc_q, kc_d;
    logic [7:0]    accepted_q, accepted_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter tracks how many back-to-back samples matched the previous
    // one. Acceptance fires on the edge where the count reaches STABLE_CYCLES,
    // so a clean change is visible here STABLE_CYCLES+1 edges after it
    // appears. The counter saturates so a held key never re-triggers.
    always_comb begin
        kc_d       = keycode_i;
        cnt_d      = cnt_q;
        accepted_d = accepted_q;
        if (keycode_i != kc_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cnt_q >= CNT_ACCEPT) begin
                accepted_d = kc_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            kc_q       <= 8'h00;
            cnt_q      <= '0;
            accepted_q <= 8'h00;
        end else begin
            kc_q       <= kc_d;
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
        end
    end

    assign accepted_o = accepted_q;

endmodule

// File: rtl/key_command_conditioner.sv
// -----------------------------------------------------------------------------
// key_command_conditioner
// Turns the raw keycode written by the soft processor into discrete game
// commands: one per press, with delayed auto-shift and auto-repeat for
// left/right, fixed-rate repeat for soft drop, and one-shot for the rest.
// Each command is held on a valid/ready handshake until consumed; commands
// generated while one is still pending are dropped, never queued.
// Ports:
//   Clk        : system clock
//   Reset      : synchronous active-high reset
//   keycode    : raw HID keycode (0x00 = no key)
//   cmd_valid  : a command is being presented
//   cmd        : command code, stable while cmd_valid is high
//   cmd_ready  : game controller takes cmd this cycle
//   key_active : accepted keycode maps to a command
// Optional build macro: KEYCOND_WASD_EN (W/A/S/D bindings, see tetris_pkg).
// -----------------------------------------------------------------------------
module key_command_conditioner
    import tetris_pkg::*;
#(
    parameter int STABLE_CYCLES    = 1000,
    parameter int DAS_DELAY        = 8000000,
    parameter int ARR_PERIOD       = 2500000,
    parameter int SOFT_DROP_PERIOD = 1500000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       cmd_valid,
    output cmd_t       cmd,
    input  logic       cmd_ready,
    output logic       key_active
);

    localparam int MAX_AB     = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
    localparam int MAX_PERIOD = (MAX_AB > SOFT_DROP_PERIOD) ? MAX_AB : SOFT_DROP_PERIOD;
    localparam int CNT_W      = ($clog2(MAX_PERIOD) < 1) ? 1 : $clog2(MAX_PERIOD);

    localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_PERIOD - 1);
    localparam logic [CNT_W-1:0] SDP_LOAD = CNT_W'(SOFT_DROP_PERIOD - 1);

    logic [7:0]       acc_kc;
    cmd_t             acc_cmd;
    cmd_t             held_cmd;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       key_q, key_d;
    logic             rep_en_q, rep_en_d;

    logic             emit;
    cmd_t             emit_cmd;
    logic             xfer;

    logic             valid_q, valid_d;
    cmd_t             cmd_q, cmd_d;
    logic             key_active_q, key_active_d;

    keycode_stabilizer #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stabilizer (
        .clk_i      (Clk),
        .reset_i    (Reset),
        .keycode_i  (keycode),
        .accepted_o (acc_kc)
    );

    assign acc_cmd  = keycode_to_cmd(acc_kc);
    assign held_cmd = keycode_to_cmd(key_q);

    // Press tracking. The repeat counter is loaded on the press edge itself
    // and keeps counting through FIRST, so the first repeat lands exactly
    // DAS_DELAY (or SOFT_DROP_PERIOD) cycles after the initial command.
    // Repeats then fire when the counter sits at zero, giving a spacing of
    // reload+1 cycles. One-shot keys park in REPEAT with repeats disabled
    // until the key is released or changed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        rep_en_d = rep_en_q;
        emit     = 1'b0;
        emit_cmd = CMD_NONE;

        case (state_q)
            ST_IDLE: begin
                if (acc_cmd != CMD_NONE) begin
                    emit     = 1'b1;
                    emit_cmd = acc_cmd;
                    key_d    = acc_kc;
                    state_d  = ST_FIRST;
                    if (is_shift_cmd(acc_cmd)) begin
                        cnt_d = DAS_LOAD;
                    end else if (acc_cmd == CMD_DOWN) begin
                        cnt_d = SDP_LOAD;
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            ST_FIRST: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (is_shift_cmd(held_cmd)) begin
                    state_d  = ST_DAS;
                    rep_en_d = 1'b1;
                end else begin
                    state_d  = ST_REPEAT;
                    rep_en_d = (held_cmd == CMD_DOWN);
                end
            end
            ST_DAS: begin
                if (cnt_q == '0) begin
                    emit     = 1'b1;
                    emit_cmd = held_cmd;
                    state_d  = ST_REPEAT;
                    cnt_d    = ARR_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (rep_en_q) begin
                    if (cnt_q == '0) begin
                        emit     = 1'b1;
                        emit_cmd = held_cmd;
                        cnt_d    = is_shift_cmd(held_cmd) ? ARR_LOAD : SDP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A change of accepted key (including release) ends the press and
        // overrides any repeat that expired on the same edge. A new mapped
        // key is picked up from IDLE on the following edge.
        if ((state_q != ST_IDLE) && (acc_kc != key_q)) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rep_en_d = 1'b0;
            emit     = 1'b0;
            emit_cmd = CMD_NONE;
        end
    end

    // Single-entry output slot. A new command only lands when the slot is
    // empty or is being drained on this same edge; otherwise it is dropped.
    always_comb begin
        xfer         = valid_q & cmd_ready;
        valid_d      = valid_q;
        cmd_d        = cmd_q;
        key_active_d = (acc_cmd != CMD_NONE);
        if (emit && (!valid_q || xfer)) begin
            valid_d = 1'b1;
            cmd_d   = emit_cmd;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            key_q        <= 8'h00;
            rep_en_q     <= 1'b0;
            valid_q      <= 1'b0;
            cmd_q        <= CMD_NONE;
            key_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            rep_en_q     <= rep_en_d;
            valid_q      <= valid_d;
            cmd_q        <= cmd_d;
            key_active_q <= key_active_d;
        end
    end

    assign cmd_valid  = valid_q;
    assign cmd        = cmd_q;
    assign key_active = key_active_q;

endmodule

// File: tb/tb_key_command_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_command_conditioner
// Directed scenarios with fixed expected command timing, followed by random
// key/ready/reset traffic, all compared cycle by cycle against a behavioural
// model built from keypress timing arithmetic.
// -----------------------------------------------------------------------------
module tb_key_command_conditioner;

    localparam int STABLE = 4;
    localparam int DAS    = 20;
    localparam int ARR    = 5;
    localparam int SDP    = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       cmdReady = 1'b1;
    logic       cmdValid;
    logic [2:0] cmdOut;
    logic       keyActive;

    int testCount = 0;
    int failCount = 0;

    // model state
    logic [7:0] histQ[$];
    logic [7:0] mAcc;
    logic [7:0] mKey;
    bit         mKeyActive;
    bit         mPend;
    bit         mPressed;
    bit         mJustReset;
    int         mCmd;
    int         mPressEdge;
    int         mEdge = 0;

    // per-phase transfer log
    bit recording = 1'b0;
    int phaseCycle = 0;
    int keyActiveSeen = 0;
    int xferCycles[$];
    int xferCmds[$];
    int expCycles[$];

    logic [7:0] keyTable [10] = '{8'h50, 8'h4F, 8'h51, 8'h52, 8'h2C,
                                  8'h42, 8'h00, 8'h04, 8'h1A, 8'h16};

    always #5 Clk = ~Clk;

    key_command_conditioner #(
        .STABLE_CYCLES    (STABLE),
        .DAS_DELAY        (DAS),
        .ARR_PERIOD       (ARR),
        .SOFT_DROP_PERIOD (SDP)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .cmd_valid  (cmdValid),
        .cmd        (cmdOut),
        .cmd_ready  (cmdReady),
        .key_active (keyActive)
    );

    // Command numbering: 0 none, 1 left, 2 right, 3 down, 4 rotate,
    // 5 hard drop, 6 restart.
    function automatic int mapKey(input logic [7:0] k);
        case (k)
            8'h50: return 1;
            8'h4F: return 2;
            8'h51: return 3;
            8'h52: return 4;
            8'h2C: return 5;
            8'h42: return 6;
`ifdef KEYCOND_WASD_EN
            8'h04: return 1;
            8'h07: return 2;
            8'h16: return 3;
            8'h1A: return 4;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        testCount++;
        if (obs != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the model, using the inputs that were present
    // before that edge.
    task automatic modelStep(input bit rst, input logic [7:0] kc, input bit rdy);
        int  a;
        int  c;
        int  el;
        int  emitCmd;
        bit  xfer;
        bit  same;
        mEdge++;
        if (rst) begin
            histQ.delete();
            histQ.push_back(8'h00);
            mAcc       = 8'h00;
            mKey       = 8'h00;
            mKeyActive = 1'b0;
            mPend      = 1'b0;
            mPressed   = 1'b0;
            mCmd       = 0;
            mJustReset = 1'b1;
            return;
        end
        mJustReset = 1'b0;
        a = int'(mAcc);
        emitCmd = 0;
        if (mPressed && mAcc != mKey) begin
            mPressed = 1'b0;
        end else if (!mPressed && mapKey(mAcc) != 0) begin
            mPressed   = 1'b1;
            mKey       = mAcc;
            mPressEdge = mEdge;
            emitCmd    = mapKey(mAcc);
        end else if (mPressed) begin
            el = mEdge - mPressEdge;
            c  = mapKey(mKey);
            if ((c == 1 || c == 2) && el >= DAS && ((el - DAS) % ARR) == 0) emitCmd = c;
            if (c == 3 && el > 0 && (el % SDP) == 0) emitCmd = c;
        end
        xfer = mPend && rdy;
        if (emitCmd != 0 && (!mPend || xfer)) begin
            mPend = 1'b1;
            mCmd  = emitCmd;
        end else if (xfer) begin
            mPend = 1'b0;
        end
        mKeyActive = (mapKey(8'(a)) != 0);
        histQ.push_back(kc);
        if (histQ.size() > STABLE + 1) void'(histQ.pop_front());
        if (histQ.size() == STABLE + 1) begin
            same = 1'b1;
            foreach (histQ[i]) if (histQ[i] != kc) same = 1'b0;
            if (same) mAcc = kc;
        end
    endtask

    // Drives one cycle of inputs, advances one edge and checks the outputs.
    task automatic applyStimulus(input bit rst, input logic [7:0] kc, input bit rdy);
        Reset    = rst;
        keycode  = kc;
        cmdReady = rdy;
        if (recording) begin
            if (cmdValid && rdy && !rst) begin
                xferCycles.push_back(phaseCycle);
                xferCmds.push_back(int'(cmdOut));
            end
            if (keyActive) keyActiveSeen++;
            phaseCycle++;
        end
        @(posedge Clk);
        #1;
        modelStep(rst, kc, rdy);
        checkOutput("cmdValid", int'(cmdValid), int'(mPend));
        checkOutput("keyActive", int'(keyActive), int'(mKeyActive));
        if (mPend) checkOutput("cmd", int'(cmdOut), mCmd);
        if (mJustReset) checkOutput("rstCmd", int'(cmdOut), 0);
    endtask

    // Reset, then hold kc for holdLen cycles and 0x00 for the rest; cmd_ready
    // is low for cycles 0..readyLowEnd. Transfers are compared with expCycles.
    task automatic runPhase(input string tag, input logic [7:0] kc, input int holdLen,
                            input int totalLen, input int readyLowEnd, input int expCmd);
        applyStimulus(1'b1, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1);
        xferCycles.delete();
        xferCmds.delete();
        keyActiveSeen = 0;
        phaseCycle = 0;
        recording = 1'b1;
        for (int j = 0; j < totalLen; j++) begin
            applyStimulus(1'b0, (j < holdLen) ? kc : 8'h00, (j > readyLowEnd));
        end
        recording = 1'b0;
        checkOutput({tag, "Count"}, xferCycles.size(), expCycles.size());
        for (int i = 0; i < expCycles.size() && i < xferCycles.size(); i++) begin
            checkOutput({tag, "Cycle"}, xferCycles[i], expCycles[i]);
            checkOutput({tag, "Cmd"}, xferCmds[i], expCmd);
        end
    endtask

    initial begin
        int cyc;
        int len;
        logic [7:0] kc;

        $display("[TB] directed scenarios");
        expCycles = '{6, 26, 31, 36, 41, 46, 51, 56, 61};
        runPhase("leftDas", 8'h50, 60, 80, -1, 1);

        expCycles = '{6};
        runPhase("rotate", 8'h52, 100, 110, -1, 4);
        runPhase("hardDrop", 8'h2C, 100, 110, -1, 5);

        expCycles = '{6, 9, 12, 15, 18, 21, 24};
        runPhase("softDrop", 8'h51, 20, 40, -1, 3);

        expCycles = '{31, 36, 41, 46};
        runPhase("rightStall", 8'h4F, 41, 60, 30, 2);

        expCycles.delete();
        runPhase("glitch", 8'h50, 2, 20, -1, 1);
        checkOutput("glitchKeyActive", keyActiveSeen, 0);

`ifdef KEYCOND_WASD_EN
        expCycles = '{6};
`else
        expCycles.delete();
`endif
        runPhase("wasdW", 8'h1A, 30, 40, -1, 4);

        applyStimulus(1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0);
        for (int j = 0; j < 8; j++) applyStimulus(1'b0, 8'h50, 1'b0);
        checkOutput("preRstValid", int'(cmdValid), 1);
        checkOutput("preRstCmd", int'(cmdOut), 1);
        applyStimulus(1'b1, 8'h50, 1'b0);
        checkOutput("postRstValid", int'(cmdValid), 0);

        $display("[TB] random traffic");
        cyc = 0;
        while (cyc < 5000) begin
            kc = ($urandom_range(0, 9) == 0) ? 8'($urandom) : keyTable[$urandom_range(0, 9)];
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                applyStimulus(($urandom_range(0, 599) == 0), kc, ($urandom_range(0, 3) != 0));
                cyc++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
